// File: rtl/axi_node_map_updater_pkg.sv
// Shared types and sizing helpers for the AXI node address-map updater.
package axi_node_map_pkg;

  // Rule storage width; ports are sized by AXI_ADDR_WIDTH and cast to/from this.
  localparam int MAP_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLOCK,
    ST_DRAIN,
    ST_APPLY
  } state_e;

  typedef struct packed {
    logic [MAP_ADDR_WIDTH-1:0] start_addr;
    logic [MAP_ADDR_WIDTH-1:0] end_addr;
    logic                      valid;
  } map_rule_t;

  function automatic int cnt_width(input int nb_slave, input int max_outstanding);
    return $clog2(nb_slave * max_outstanding + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_node_map_updater_if.sv
// Per-slave-port handshake observation and AW/AR gating bundle.
interface axi_node_map_updater_if #(
  parameter int NB_SLAVE = 4
);
  logic [NB_SLAVE-1:0] aw_hs;
  logic [NB_SLAVE-1:0] ar_hs;
  logic [NB_SLAVE-1:0] b_hs;
  logic [NB_SLAVE-1:0] r_last_hs;
  logic [NB_SLAVE-1:0] block;

  modport master (output aw_hs, ar_hs, b_hs, r_last_hs, input block);
  modport slave  (input aw_hs, ar_hs, b_hs, r_last_hs, output block);
endinterface

// File: rtl/axi_node_outstanding_cnt.sv
// Outstanding-transaction counter: net popcount increment/decrement per cycle, wraps in hardware.
module axi_node_outstanding_cnt #(
  parameter int NB_PORT = 4,
  parameter int MAX_CNT = 64,
  parameter int CNT_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NB_PORT-1:0] inc_i,
  input  logic [NB_PORT-1:0] dec_i,
  output logic               zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'($countones(inc_i)) - CNT_W'($countones(dec_i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      // Underflow or overflow means the integration miscounted handshakes.
      assert (int'(cnt_q) + $countones(inc_i) - $countones(dec_i) >= 0);
      assert (int'(cnt_q) + $countones(inc_i) - $countones(dec_i) <= MAX_CNT);
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/axi_node_map_updater.sv
// Shadow/active address-map controller: gates AW/AR, drains, then swaps the map atomically.
// Optional drain timeout enabled by defining AXI_NODE_MAP_TIMEOUT_EN.
module axi_node_map_updater
  import axi_node_map_pkg::*;
#(
  parameter int NB_SLAVE        = 4,
  parameter int NB_MASTER       = 4,
  parameter int NB_REGION       = 1,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                shadow_we_i,
  input  logic [idx_width(NB_REGION)-1:0]     shadow_region_i,
  input  logic [idx_width(NB_MASTER)-1:0]     shadow_master_i,
  input  logic [AXI_ADDR_WIDTH-1:0]           shadow_start_i,
  input  logic [AXI_ADDR_WIDTH-1:0]           shadow_end_i,
  input  logic                                shadow_valid_i,
  input  logic                                commit_req_i,
  output logic                                busy_o,
  output logic                                commit_done_o,
  output logic                                commit_err_o,
  axi_node_map_updater_if.slave               hs_if,
  output logic [NB_REGION-1:0][NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0] start_addr_o,
  output logic [NB_REGION-1:0][NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0] end_addr_o,
  output logic [NB_REGION-1:0][NB_MASTER-1:0]                     valid_rule_o
);
  localparam int REG_W = idx_width(NB_REGION);
  localparam int MST_W = idx_width(NB_MASTER);
  localparam int CNT_W = cnt_width(NB_SLAVE, MAX_OUTSTANDING);

  state_e state_q, state_d;
  logic   block_q, done_q, apply;
  logic   wr_zero, rd_zero;

  axi_node_outstanding_cnt #(.NB_PORT(NB_SLAVE), .MAX_CNT(NB_SLAVE*MAX_OUTSTANDING), .CNT_W(CNT_W)) u_wr_cnt (
    .clk(clk), .rst(rst), .inc_i(hs_if.aw_hs), .dec_i(hs_if.b_hs), .zero_o(wr_zero)
  );
  axi_node_outstanding_cnt #(.NB_PORT(NB_SLAVE), .MAX_CNT(NB_SLAVE*MAX_OUTSTANDING), .CNT_W(CNT_W)) u_rd_cnt (
    .clk(clk), .rst(rst), .inc_i(hs_if.ar_hs), .dec_i(hs_if.r_last_hs), .zero_o(rd_zero)
  );

`ifdef AXI_NODE_MAP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q;
  logic            err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= (state_q == ST_DRAIN) ? to_q + 1'b1 : '0;
      err_q <= err_d;
    end
  end
  assign commit_err_o = err_q;
`else
  assign commit_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
`ifdef AXI_NODE_MAP_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE:  if (commit_req_i) state_d = ST_BLOCK;
      ST_BLOCK: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (wr_zero && rd_zero) begin
          state_d = ST_APPLY;
`ifdef AXI_NODE_MAP_TIMEOUT_EN
        end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
`endif
        end
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        apply   = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      block_q <= 1'b0;
      done_q  <= 1'b0;
      assert (TIMEOUT_CYCLES > 0);
    end else begin
      state_q <= state_d;
      block_q <= (state_d != ST_IDLE);
      done_q  <= apply;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign commit_done_o = done_q;
  assign hs_if.block   = {NB_SLAVE{block_q}};

  // One shadow/active rule pair per (region, master); a write during APPLY lands in both.
  for (genvar gi = 0; gi < NB_REGION; gi++) begin : g_region
    for (genvar gj = 0; gj < NB_MASTER; gj++) begin : g_master
      map_rule_t shadow_q, shadow_d, active_q;

      always_comb begin
        shadow_d = shadow_q;
        if (shadow_we_i && shadow_region_i == REG_W'(gi) && shadow_master_i == MST_W'(gj)) begin
          shadow_d.start_addr = MAP_ADDR_WIDTH'(shadow_start_i);
          shadow_d.end_addr   = MAP_ADDR_WIDTH'(shadow_end_i);
          shadow_d.valid      = shadow_valid_i;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_q <= '0;
          active_q <= '0;
        end else begin
          shadow_q <= shadow_d;
          if (apply) active_q <= shadow_d;
        end
      end

      assign start_addr_o[gi][gj] = AXI_ADDR_WIDTH'(active_q.start_addr);
      assign end_addr_o[gi][gj]   = AXI_ADDR_WIDTH'(active_q.end_addr);
      assign valid_rule_o[gi][gj] = active_q.valid;
    end
  end
endmodule

// File: tb/tb_axi_node_map_updater.sv
// Directed bench for axi_node_map_updater: idle/outstanding commits, ignored re-request, reset mid-commit, timeout.
module tb_axi_node_map_updater;
  localparam int NS = 4;
  localparam int NM = 4;
  localparam int NR = 1;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          sh_we, sh_region, sh_valid;
  logic [1:0]    sh_master;
  logic [AW-1:0] sh_start, sh_end;
  logic          commit_req, busy, done, err;
  logic [NR-1:0][NM-1:0][AW-1:0] start_addr, end_addr;
  logic [NR-1:0][NM-1:0]         valid_rule;
  int checks = 0;
  int failures = 0;
  int done_cnt;

  axi_node_map_updater_if #(.NB_SLAVE(NS)) hs_if ();

  axi_node_map_updater #(
    .NB_SLAVE(NS), .NB_MASTER(NM), .NB_REGION(NR), .AXI_ADDR_WIDTH(AW),
    .MAX_OUTSTANDING(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .shadow_we_i(sh_we), .shadow_region_i(sh_region), .shadow_master_i(sh_master),
    .shadow_start_i(sh_start), .shadow_end_i(sh_end), .shadow_valid_i(sh_valid),
    .commit_req_i(commit_req), .busy_o(busy), .commit_done_o(done), .commit_err_o(err),
    .hs_if(hs_if),
    .start_addr_o(start_addr), .end_addr_o(end_addr), .valid_rule_o(valid_rule)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hs_idle();
    hs_if.aw_hs = '0;
    hs_if.ar_hs = '0;
    hs_if.b_hs = '0;
    hs_if.r_last_hs = '0;
  endtask

  task automatic shadow_write(input logic [1:0] m, input logic [AW-1:0] s, input logic [AW-1:0] e,
                              input logic v);
    sh_we = 1'b1; sh_master = m; sh_start = s; sh_end = e; sh_valid = v;
    tick();
    sh_we = 1'b0;
  endtask

  // Cycle numbering: cycle 0 carries commit_req; block/busy expected in cycles 1..last_block.
  task automatic check_cycle(input string tag, input int cyc, input int last_block,
                             input int done_at, input int err_at);
    logic in_block;
    in_block = (cyc >= 1 && cyc <= last_block);
    check_eq($sformatf("%s_c%0d_block", tag, cyc), 64'(hs_if.block), in_block ? 64'hF : 64'h0);
    check_eq($sformatf("%s_c%0d_busy", tag, cyc), 64'(busy), 64'(in_block));
    check_eq($sformatf("%s_c%0d_done", tag, cyc), 64'(done), 64'(cyc == done_at));
    check_eq($sformatf("%s_c%0d_err", tag, cyc), 64'(err), 64'(cyc == err_at));
    if (done) done_cnt++;
  endtask

  initial begin
    rst = 1'b1; sh_we = 1'b0; sh_region = 1'b0; sh_valid = 1'b0; sh_master = '0;
    sh_start = '0; sh_end = '0; commit_req = 1'b0;
    hs_idle();
    tick(); tick();
    check_eq("rst_block", 64'(hs_if.block), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_done", 64'(done), 64'h0);
    check_eq("rst_err", 64'(err), 64'h0);
    check_eq("rst_valid", 64'(valid_rule), 64'h0);
    check_eq("rst_start0", 64'(start_addr[0][0]), 64'h0);
    rst = 1'b0;
    tick();

    // Idle-bus commit: map appears with done at t+4.
    shadow_write(2'd0, 32'h1000, 32'h1FFF, 1'b1);
    check_eq("idle_pre_valid", 64'(valid_rule), 64'h0);
    for (int i = 0; i <= 5; i++) begin
      commit_req = (i == 0);
      tick();
      check_cycle("idle", i + 1, 3, 4, -1);
      if (i + 1 == 3) check_eq("idle_apply_valid", 64'(valid_rule), 64'h0);
    end
    commit_req = 1'b0;
    check_eq("idle_valid", 64'(valid_rule), 64'h1);
    check_eq("idle_start0", 64'(start_addr[0][0]), 64'h1000);
    check_eq("idle_end0", 64'(end_addr[0][0]), 64'h1FFF);

    // Three AWs outstanding on port 1, B returns in cycles 10..12; write during APPLY included.
    shadow_write(2'd1, 32'h2000, 32'h2FFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      hs_if.aw_hs = 4'b0010;
      tick();
    end
    hs_idle();
    for (int i = 0; i <= 17; i++) begin
      hs_idle();
      sh_we = 1'b0;
      commit_req = (i == 0);
      if (i >= 10 && i <= 12) hs_if.b_hs = 4'b0010;
      if (i == 14) begin
        sh_we = 1'b1; sh_master = 2'd2; sh_start = 32'h4000; sh_end = 32'h4FFF; sh_valid = 1'b1;
      end
      tick();
      check_cycle("outst", i + 1, 14, 15, -1);
    end
    sh_we = 1'b0; commit_req = 1'b0; hs_idle();
    check_eq("outst_valid", 64'(valid_rule), 64'h7);
    check_eq("outst_start1", 64'(start_addr[0][1]), 64'h2000);
    check_eq("outst_start2", 64'(start_addr[0][2]), 64'h4000);
    check_eq("outst_end2", 64'(end_addr[0][2]), 64'h4FFF);

    // Simultaneous AW p0 + B p2 nets to zero; AR on p0 and p1 adds two; re-request in DRAIN ignored.
    shadow_write(2'd0, 32'h1000, 32'h1FFF, 1'b0);
    shadow_write(2'd3, 32'h3000, 32'h3FFF, 1'b1);
    hs_if.aw_hs = 4'b0001; hs_if.ar_hs = 4'b0011;
    tick();
    hs_idle();
    hs_if.aw_hs = 4'b0001; hs_if.b_hs = 4'b0100;
    tick();
    done_cnt = 0;
    for (int i = 0; i <= 15; i++) begin
      hs_idle();
      commit_req = (i == 0 || i == 3);
      if (i == 5) hs_if.b_hs = 4'b0100;
      if (i == 6) hs_if.r_last_hs = 4'b0001;
      if (i == 7) hs_if.r_last_hs = 4'b0010;
      tick();
      check_cycle("net", i + 1, 9, 10, -1);
    end
    commit_req = 1'b0; hs_idle();
    check_eq("net_done_count", 64'(done_cnt), 64'd1);
    check_eq("net_valid", 64'(valid_rule), 64'hE);
    check_eq("net_start3", 64'(start_addr[0][3]), 64'h3000);
    check_eq("net_end3", 64'(end_addr[0][3]), 64'h3FFF);

`ifdef AXI_NODE_MAP_TIMEOUT_EN
    // B withheld: DRAIN gives up after 8 cycles, error pulse, old map kept.
    shadow_write(2'd1, 32'h2000, 32'h2FFF, 1'b0);
    hs_if.aw_hs = 4'b0001;
    tick();
    hs_idle();
    done_cnt = 0;
    for (int i = 0; i <= 12; i++) begin
      commit_req = (i == 0);
      tick();
      check_cycle("tmo", i + 1, 9, -1, 10);
    end
    commit_req = 1'b0;
    check_eq("tmo_done_count", 64'(done_cnt), 64'd0);
    check_eq("tmo_valid", 64'(valid_rule), 64'hE);
    hs_if.b_hs = 4'b0001;
    tick();
    hs_idle();
`endif

    // Reset while draining: block, busy and active map clear on the next cycle.
    hs_if.aw_hs = 4'b1000;
    tick();
    hs_idle();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    check_eq("rstmid_busy_pre", 64'(busy), 64'h1);
    check_eq("rstmid_block_pre", 64'(hs_if.block), 64'hF);
    rst = 1'b1;
    tick();
    check_eq("rstmid_block", 64'(hs_if.block), 64'h0);
    check_eq("rstmid_busy", 64'(busy), 64'h0);
    check_eq("rstmid_valid", 64'(valid_rule), 64'h0);
    check_eq("rstmid_start3", 64'(start_addr[0][3]), 64'h0);
    rst = 1'b0;
    tick();
    // Shadow was cleared too, so a fresh commit keeps the map empty.
    for (int i = 0; i <= 5; i++) begin
      commit_req = (i == 0);
      tick();
      check_cycle("postrst", i + 1, 3, 4, -1);
    end
    commit_req = 1'b0;
    check_eq("postrst_valid", 64'(valid_rule), 64'h0);
    check_eq("postrst_end2", 64'(end_addr[0][2]), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
